// File: rtl/icache_fetch_responder_if.sv
`default_nettype none
// ============================================================================
// icache_fetch_responder_if : fetch-port and physical-memory-port bundle
// Rev 1.0
// ============================================================================
interface icache_fetch_responder_if;
  logic         inst_read;
  logic [15:0]  inst_addr;
  logic [15:0]  inst_rdata;
  logic         inst_resp;
  logic         flush;
  logic         pmem_read;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  // Environment side: fetch stage plus physical memory
  modport master (
    output inst_read, inst_addr, flush, pmem_rdata, pmem_resp,
    input  inst_rdata, inst_resp, pmem_read, pmem_address
  );

  // Cache side
  modport slave (
    input  inst_read, inst_addr, flush, pmem_rdata, pmem_resp,
    output inst_rdata, inst_resp, pmem_read, pmem_address
  );
endinterface
`default_nettype wire

// File: rtl/icache_fetch_responder.sv
`default_nettype none
// ============================================================================
// icache_fetch_responder : direct-mapped I-cache, zero-latency hits, line fill
// Rev 1.0
// ============================================================================
module icache_fetch_responder #(
  parameter int NUM_SETS = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  icache_fetch_responder_if.slave  bus
);

  localparam int IDX = $clog2(NUM_SETS);
  localparam int TAG = 12 - IDX;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FILL  = 2'd2;

  logic [1:0]     state;
  logic [1:0]     state_next;

  logic [127:0]   line_data  [NUM_SETS];
  logic [TAG-1:0] line_tag   [NUM_SETS];
  logic           line_valid [NUM_SETS];

  logic [TAG-1:0] req_tag;
  logic [IDX-1:0] req_idx;
  logic [2:0]     req_word;
  logic [TAG-1:0] fill_tag;
  logic [IDX-1:0] fill_idx;
  logic [127:0]   hit_line;

  logic           hit;
  logic           miss;
  logic           fill_done;
  logic           fill_kill;
  logic           pmem_read_q;
  logic [15:0]    pmem_addr_q;
  logic           inst_resp_c;
  logic [15:0]    inst_rdata_c;
  logic           unused_addr_lsb;

  assign req_tag         = bus.inst_addr[15:4+IDX];
  assign req_idx         = bus.inst_addr[3+IDX:4];
  assign req_word        = bus.inst_addr[3:1];
  assign unused_addr_lsb = bus.inst_addr[0];

  assign fill_tag  = pmem_addr_q[15:4+IDX];
  assign fill_idx  = pmem_addr_q[3+IDX:4];
  assign hit_line  = line_data[req_idx];

  // Lookup only in IDLE; flush takes effect at the edge, so this uses pre-flush valids
  assign hit       = (state == S_IDLE) && bus.inst_read &&
                     line_valid[req_idx] && (line_tag[req_idx] == req_tag);
  assign miss      = (state == S_IDLE) && bus.inst_read && !hit;
  assign fill_done = (state == S_FETCH) && bus.pmem_resp;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (miss) state_next = S_FETCH;
      S_FETCH: if (bus.pmem_resp) state_next = S_FILL;
      S_FILL:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    inst_resp_c  = 1'b0;
    inst_rdata_c = 16'h0000;
    if (hit) begin
      inst_resp_c  = 1'b1;
      inst_rdata_c = hit_line[{req_word, 4'b0000} +: 16];
    end
  end

  assign bus.inst_resp    = inst_resp_c;
  assign bus.inst_rdata   = inst_rdata_c;
  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_address = pmem_addr_q;

  // ---------------------------------------------------------------- pmem side
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pmem_read_q <= 1'b0;
      pmem_addr_q <= 16'h0000;
      fill_kill   <= 1'b0;
    end else begin
      pmem_read_q <= (state_next == S_FETCH);
      if (miss) begin
        pmem_addr_q <= {bus.inst_addr[15:4], 4'b0000};
      end
      // A flush seen while the line is outstanding makes the fill land invalid
      fill_kill <= (state_next == S_FETCH) &&
                   (fill_kill || ((state == S_FETCH) && bus.flush));
    end
  end

  // ---------------------------------------------------------------- storage
  for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        line_valid[s] <= 1'b0;
      end else if (bus.flush) begin
        line_valid[s] <= 1'b0;
      end else if (fill_done && (fill_idx == IDX'(s))) begin
        line_valid[s] <= !fill_kill;
      end
    end

    always_ff @(posedge clk) begin
      if (fill_done && (fill_idx == IDX'(s))) begin
        line_data[s] <= bus.pmem_rdata;
        line_tag[s]  <= fill_tag;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_fetch_responder.sv
`default_nettype none
// ============================================================================
// tb_icache_fetch_responder : randomized fetch traffic against a line-level model
// Rev 1.0
// ============================================================================
module tb_icache_fetch_responder;

  localparam int NS = 8;
  localparam int IW = $clog2(NS);

  logic clk = 1'b0;
  logic reset_n;

  icache_fetch_responder_if bus();

  icache_fetch_responder #(.NUM_SETS(NS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  bit           m_valid [NS];
  int unsigned  m_tag   [NS];
  logic [127:0] m_line  [NS];
  logic [127:0] mem     [int];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mem_line(input int la);
    if (!mem.exists(la)) mem[la] = {$urandom, $urandom, $urandom, $urandom};
    return mem[la];
  endfunction

  function automatic int idx_of(input logic [15:0] a);
    return (int'(a) >> 4) % NS;
  endfunction

  function automatic int unsigned tag_of(input logic [15:0] a);
    return int'(a) >> (4 + IW);
  endfunction

  function automatic bit m_hit(input logic [15:0] a);
    return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
  endfunction

  function automatic logic [15:0] m_word(input logic [15:0] a);
    logic [127:0] l;
    l = m_line[idx_of(a)];
    return l[((int'(a) >> 1) % 8) * 16 +: 16];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.inst_read = 1'b0; bus.inst_addr = 16'($urandom); bus.flush = 1'b0; bus.pmem_resp = 1'b0;
    #1;
    chk("idle_resp", bus.inst_resp, 1'b0);
    chk("idle_data", bus.inst_rdata, 16'h0);
    chk("idle_pmem_read", bus.pmem_read, 1'b0);
  endtask

  // Flush in IDLE; request only issued when it is a hit, so no fill follows
  task automatic idle_flush(input logic [15:0] a);
    bit h;
    h = m_hit(a);
    @(negedge clk);
    bus.inst_read = h; bus.inst_addr = a; bus.flush = 1'b1; bus.pmem_resp = 1'b0;
    #1;
    chk("flush_lookup_resp", bus.inst_resp, h);
    if (h) chk("flush_lookup_data", bus.inst_rdata, m_word(a));
    m_clear();
  endtask

  task automatic fetch(input logic [15:0] a, input int lat, input bit fl,
                       input bit sw, input logic [15:0] a2, input bit drp);
    logic [15:0] cur;
    logic [15:0] la;
    bit kill, done, rd;
    cur = a; done = 1'b0; rd = 1'b1;
    for (int tries = 0; tries < 4 && !done; tries++) begin
      @(negedge clk);
      bus.inst_read = rd; bus.inst_addr = cur; bus.flush = 1'b0; bus.pmem_resp = 1'b0;
      bus.pmem_rdata = {4{$urandom}};
      #1;
      if (!rd) begin
        chk("drop_no_resp", bus.inst_resp, 1'b0);
        chk("drop_pmem_idle", bus.pmem_read, 1'b0);
        done = 1'b1;
      end else if (m_hit(cur)) begin
        chk("hit_resp", bus.inst_resp, 1'b1);
        chk("hit_data", bus.inst_rdata, m_word(cur));
        chk("hit_no_pmem", bus.pmem_read, 1'b0);
        done = 1'b1;
      end else begin
        chk("miss_resp", bus.inst_resp, 1'b0);
        chk("miss_data", bus.inst_rdata, 16'h0);
        la = {cur[15:4], 4'h0};
        kill = 1'b0;
        for (int c = 0; c <= lat; c++) begin
          @(negedge clk);
          if (c == 0 && sw) cur = a2;
          if (c == 0 && drp) rd = 1'b0;
          bus.inst_read  = rd;
          bus.inst_addr  = cur;
          bus.flush      = (c == 0) && fl;
          bus.pmem_resp  = (c == lat);
          bus.pmem_rdata = (c == lat) ? mem_line(la) : {4{$urandom}};
          #1;
          chk("fetch_pmem_read", bus.pmem_read, 1'b1);
          chk("fetch_addr", bus.pmem_address, la);
          chk("fetch_resp", bus.inst_resp, 1'b0);
          chk("fetch_data", bus.inst_rdata, 16'h0);
          if (bus.flush) begin
            m_clear();
            kill = 1'b1;
          end
        end
        m_line[idx_of(la)]  = mem_line(la);
        m_tag[idx_of(la)]   = tag_of(la);
        m_valid[idx_of(la)] = !kill;
        fl = 1'b0; sw = 1'b0; drp = 1'b0;
        @(negedge clk);
        bus.pmem_resp = 1'b0; bus.flush = 1'b0; bus.inst_read = rd; bus.inst_addr = cur;
        #1;
        chk("fill_pmem_read", bus.pmem_read, 1'b0);
        chk("fill_resp", bus.inst_resp, 1'b0);
      end
    end
    if (!done) chk("fetch_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.inst_read = 1'b0; bus.inst_addr = 16'h0; bus.flush = 1'b0;
    bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pmem_read", bus.pmem_read, 1'b0);
    chk("rst_pmem_addr", bus.pmem_address, 16'h0);
    chk("rst_resp", bus.inst_resp, 1'b0);
    chk("rst_data", bus.inst_rdata, 16'h0);
    reset_n = 1'b1;
    m_clear();
  endtask

  task automatic reset_mid_fetch(input logic [15:0] a);
    idle_flush(a);
    @(negedge clk);
    bus.inst_read = 1'b1; bus.inst_addr = a; bus.flush = 1'b0; bus.pmem_resp = 1'b0;
    #1;
    chk("rmf_miss", bus.inst_resp, 1'b0);
    @(negedge clk);
    #1;
    chk("rmf_fetch", bus.pmem_read, 1'b1);
    reset_n = 1'b0; bus.inst_read = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; bus.pmem_resp = 1'b1; bus.pmem_rdata = mem_line({a[15:4], 4'h0});
    #1;
    chk("rmf_pmem_read", bus.pmem_read, 1'b0);
    chk("rmf_pmem_addr", bus.pmem_address, 16'h0);
    chk("rmf_resp", bus.inst_resp, 1'b0);
    m_clear();
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    #1;
    chk("rmf_late_ignored", bus.pmem_read, 1'b0);
    fetch(a, 1, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    a = 16'(($urandom_range(0, 3) << (4 + IW)) | ($urandom_range(0, NS - 1) << 4) |
            ($urandom_range(0, 7) << 1) | $urandom_range(0, 1));
    return a;
  endfunction

  initial begin
    logic [127:0] l;
    int op;
    do_reset();

    // Line 0x0040 carries 0x1234 in word 2
    l = {$urandom, $urandom, $urandom, $urandom};
    l[47:32] = 16'h1234;
    mem[32'h40] = l;
    fetch(16'h0040, 2, 1'b0, 1'b0, 16'h0, 1'b0);
    fetch(16'h0044, 0, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("word2_const", bus.inst_rdata, 16'h1234);

    for (int w = 0; w < 8; w++) fetch(16'(16'h0040 + 2 * w), 0, 1'b0, 1'b0, 16'h0, 1'b0);

    fetch(16'h00C0, 1, 1'b0, 1'b0, 16'h0, 1'b0);
    fetch(16'h0040, 0, 1'b0, 1'b0, 16'h0, 1'b0);

    fetch(16'h0100, 3, 1'b1, 1'b0, 16'h0, 1'b0);
    fetch(16'h0200, 0, 1'b1, 1'b0, 16'h0, 1'b0);

    idle_flush(16'h0042);
    fetch(16'h0042, 1, 1'b0, 1'b0, 16'h0, 1'b0);

    reset_mid_fetch(16'h0046);

    fetch(16'h0100, 2, 1'b0, 1'b1, 16'h0046, 1'b0);
    fetch(16'h0300, 1, 1'b0, 1'b0, 16'h0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 99);
      if (op < 70)
        fetch(rand_addr(), $urandom_range(0, 3), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 9) == 0), rand_addr(), ($urandom_range(0, 19) == 0));
      else if (op < 78)
        idle_flush(rand_addr());
      else
        idle_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
    $fatal(1);
  end

endmodule
`default_nettype wire
